// File: rtl/regfile_bank_read_ctrl_pkg.sv
// Shared types and address helpers for the banked register-file read controller.
package regfile_bank_read_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  // Low address bits select the bank so consecutive registers spread across banks.
  function automatic int unsigned addr_bank(input int unsigned addr, input int unsigned bank_w);
    return addr & ((32'd1 << bank_w) - 32'd1);
  endfunction

  function automatic int unsigned addr_row(input int unsigned addr, input int unsigned bank_w);
    return addr >> bank_w;
  endfunction

endpackage

// File: rtl/regfile_bank_read_ctrl_bank_grant.sv
// Per-bank arbiter: picks the lowest pending port on this bank and merges same-row requests.
module regfile_bank_read_ctrl_bank_grant
  import regfile_bank_read_ctrl_pkg::*;
#(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned AddrW    = 4,
  parameter int unsigned BankW    = 2,
  parameter int unsigned BankIdx  = 0,
  localparam int unsigned RowW    = AddrW - BankW
) (
  input  logic [NumPorts-1:0]       pending_i,
  input  logic [NumPorts*AddrW-1:0] addr_i,
  output logic [NumPorts-1:0]       grant_o,
  output logic [RowW-1:0]           row_o,
  output logic                      re_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    row_o   = '0;
    found   = 1'b0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      int unsigned addr_p;
      addr_p = 32'(addr_i[p*AddrW +: AddrW]);
      if (pending_i[p] && (addr_bank(addr_p, BankW) == BankIdx)) begin
        // First hit fixes the row; later hits ride along only if they match it.
        if (!found) begin
          found = 1'b1;
          row_o = RowW'(addr_row(addr_p, BankW));
        end
        if (RowW'(addr_row(addr_p, BankW)) == row_o) begin
          grant_o[p] = 1'b1;
        end
      end
    end
  end

  assign re_o = found;

endmodule

// File: rtl/regfile_bank_read_ctrl.sv
// Banked register-file read controller: accepts a port bundle, serialises bank conflicts,
// and returns all port results together.
module regfile_bank_read_ctrl
  import regfile_bank_read_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned DATA_W     = 16,
  localparam int unsigned BANK_W    = $clog2(NUM_BANKS),
  localparam int unsigned ROW_W     = REG_ADDR_W - BANK_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_PORTS-1:0]             req_en,
  input  logic [NUM_PORTS*REG_ADDR_W-1:0]  req_addr,
  output logic [NUM_BANKS-1:0]             bank_re,
  output logic [NUM_BANKS*ROW_W-1:0]       bank_row,
  input  logic [NUM_BANKS*DATA_W-1:0]      bank_rdata,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_PORTS*DATA_W-1:0]      rd_data
);

  state_e                          state_q, state_d;
  logic [NUM_PORTS*REG_ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_PORTS-1:0]            pend_q, pend_d;
  logic [NUM_PORTS-1:0]            gvld_q, gvld_d;
  logic [BANK_W-1:0]               gbank_q [NUM_PORTS];
  logic [BANK_W-1:0]               gbank_d [NUM_PORTS];
  logic [NUM_PORTS*DATA_W-1:0]     rd_data_q, rd_data_d;

  logic [NUM_PORTS-1:0] grant_b [NUM_BANKS];
  logic [ROW_W-1:0]     row_b [NUM_BANKS];
  logic [NUM_BANKS-1:0] re_b;
  logic [NUM_PORTS-1:0] grant_all;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    regfile_bank_read_ctrl_bank_grant #(
      .NumPorts (NUM_PORTS),
      .AddrW    (REG_ADDR_W),
      .BankW    (BANK_W),
      .BankIdx  (b)
    ) u_bank_grant (
      .pending_i (pend_q),
      .addr_i    (addr_q),
      .grant_o   (grant_b[b]),
      .row_o     (row_b[b]),
      .re_o      (re_b[b])
    );
  end

  // Port -> bank map of this cycle's grants, registered to steer next cycle's read data.
  always_comb begin
    grant_all = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      grant_all = grant_all | grant_b[b];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      gbank_d[p] = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (grant_b[b][p]) gbank_d[p] = BANK_W'(b);
      end
    end
  end

  always_comb begin
    bank_re  = '0;
    bank_row = '0;
    if (state_q == StIssue) begin
      bank_re = re_b;
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_row[b*ROW_W +: ROW_W] = row_b[b];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pend_d    = pend_q;
    gvld_d    = '0;
    rd_data_d = rd_data_q;

    if ((state_q == StIssue) || (state_q == StWait)) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (gvld_q[p]) begin
          rd_data_d[p*DATA_W +: DATA_W] = bank_rdata[32'(gbank_q[p])*DATA_W +: DATA_W];
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          addr_d    = req_addr;
          pend_d    = req_en;
          rd_data_d = '0;
          state_d   = (req_en == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        gvld_d = grant_all;
        pend_d = pend_q & ~grant_all;
        if (pend_d == '0) state_d = StWait;
      end
      StWait:  state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      pend_q    <= '0;
      gvld_q    <= '0;
      rd_data_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) gbank_q[p] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pend_q    <= pend_d;
      gvld_q    <= gvld_d;
      rd_data_q <= rd_data_d;
      for (int p = 0; p < NUM_PORTS; p++) gbank_q[p] <= gbank_d[p];
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_regfile_bank_read_ctrl.sv
// Self-checking bench for regfile_bank_read_ctrl: vector table plus hand-written corner sequences,
// with a result scoreboard fed at bundle acceptance.
module tb_regfile_bank_read_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  req_en;
  logic [7:0]  req_addr;
  logic [3:0]  bank_re;
  logic [7:0]  bank_row;
  logic [63:0] bank_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [1:0] en;
    logic [3:0] a0;
    logic [3:0] a1;
    int         lat;
    logic [3:0] re1;
    logic [7:0] row1;
  } vec_t;

  vec_t vecs[8];

  regfile_bank_read_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .req_en     (req_en),
    .req_addr   (req_addr),
    .bank_re    (bank_re),
    .bank_row   (bank_row),
    .bank_rdata (bank_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  // Bank stub: data for register addr is 16'hA000 + addr, one cycle after the read enable.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bank_re[b]) bank_rdata[b*16 +: 16] <= 16'hA000 + 16'({bank_row[b*2 +: 2], 2'(b)});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [1:0] en, input logic [3:0] a0,
                                           input logic [3:0] a1);
    logic [31:0] r;
    r = '0;
    if (en[0]) r[15:0]  = 16'hA000 + {12'h0, a0};
    if (en[1]) r[31:16] = 16'hA000 + {12'h0, a1};
    return r;
  endfunction

  // Scoreboard consumer: compare every result transfer against the oldest accepted bundle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got rd_data %h expected no transfer", rd_data);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("rd_data", 64'(rd_data), 64'(e));
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the result transfer.
  task automatic run_vec(input vec_t v);
    int n;
    in_valid = 1'b1;
    req_en   = v.en;
    req_addr = {v.a1, v.a0};
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    @(posedge clk);
    sb.push_back(exp_data(v.en, v.a0, v.a1));
    #1 in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    check("bank_re_t1", 64'(bank_re), 64'(v.re1));
    check("bank_row_t1", 64'(bank_row), 64'(v.row1));
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(v.lat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b11, 4'd1, 4'd2,  3, 4'b0110, 8'h00};
    vecs[1] = '{2'b11, 4'd1, 4'd5,  4, 4'b0010, 8'h00};
    vecs[2] = '{2'b11, 4'd6, 4'd6,  3, 4'b0100, 8'h10};
    vecs[3] = '{2'b01, 4'd3, 4'd9,  3, 4'b1000, 8'h00};
    vecs[4] = '{2'b00, 4'd4, 4'd7,  1, 4'b0000, 8'h00};
    vecs[5] = '{2'b11, 4'd0, 4'd15, 3, 4'b1001, 8'hC0};
    vecs[6] = '{2'b11, 4'd3, 4'd7,  4, 4'b1000, 8'h00};
    vecs[7] = '{2'b10, 4'd5, 4'd9,  3, 4'b0010, 8'h08};

    rst = 1'b1; in_valid = 1'b0; req_en = '0; req_addr = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_bank_re", 64'(bank_re), 64'(0));
    check("rst_bank_row", 64'(bank_row), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Bank-1 conflict: second row issued on the following cycle.
    in_valid = 1'b1; req_en = 2'b11; req_addr = {4'd5, 4'd1};
    @(posedge clk);
    sb.push_back(exp_data(2'b11, 4'd1, 4'd5));
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("cf_re_t1", 64'(bank_re), 64'(4'b0010));
    check("cf_row_t1", 64'(bank_row), 64'(8'h00));
    @(negedge clk);
    check("cf_re_t2", 64'(bank_re), 64'(4'b0010));
    check("cf_row_t2", 64'(bank_row), 64'(8'h04));
    @(negedge clk);
    check("cf_re_t3", 64'(bank_re), 64'(0));
    check("cf_ov_t3", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("cf_ov_t4", 64'(out_valid), 64'(1));
    check("cf_ir_t4", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;

    // Back-pressure in DONE while a new bundle waits on the input.
    out_ready = 1'b0; in_valid = 1'b1; req_en = 2'b11; req_addr = {4'd2, 4'd1};
    @(posedge clk);
    sb.push_back(exp_data(2'b11, 4'd1, 4'd2));
    #1 req_addr = {4'd6, 4'd6};
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_out_valid", 64'(out_valid), 64'(1));
      check("hold_in_ready", 64'(in_ready), 64'(0));
      check("hold_rd_data", 64'(rd_data), 64'(exp_data(2'b11, 4'd1, 4'd2)));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("no_bypass_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("after_xfer_in_ready", 64'(in_ready), 64'(1));
    check("after_xfer_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    sb.push_back(exp_data(2'b11, 4'd6, 4'd6));
    #1 in_valid = 1'b0;
    begin
      int n;
      n = 1;
      @(negedge clk);
      check("bp2_re_t1", 64'(bank_re), 64'(4'b0100));
      check("bp2_row_t1", 64'(bank_row), 64'(8'h10));
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("bp2_latency", 64'(n), 64'(3));
    end
    @(posedge clk);
    #1;

    // Reset in the middle of a conflicting bundle, then a clean bundle.
    in_valid = 1'b1; req_en = 2'b11; req_addr = {4'd5, 4'd1};
    @(posedge clk);
    #1 in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_rst_issue_re", 64'(bank_re), 64'(4'b0010));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_bank_re", 64'(bank_re), 64'(0));
    check("mid_rst_bank_row", 64'(bank_row), 64'(0));
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    check("mid_rst_rd_data", 64'(rd_data), 64'(0));
    @(posedge clk);
    #1;
    run_vec(vecs[0]);

    repeat (2) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
